prio_rr_arbiter: RTL and testbench
==================================

// Module: prio_rr_arbiter
// PURPOSE
//  Registered N-way request arbiter; successor to our combinational priority encoder.
//  Selectable fixed (highest index wins) or round-robin priority. Grant held with valid/ready handshake.
//  Sits between N requesting channels and one shared resource; one grant per cycle sustained.
// PARAMETERS
//  N      8            number of request lines (>=2)
//  IDX_W  $clog2(N)    width of grant index (localparam, derived)
// PORTS
//  clk         in   1      single clock, all state on rising edge
//  rst_n       in   1      asynchronous active-low reset
//  req         in   N      request vector, bit i = channel i
//  mode        in   1      0 = fixed priority, 1 = round-robin
//  gnt_ready   in   1      consumer accepts current grant
//  gnt_valid   out  1      grant registered and stable
//  gnt_idx     out  IDX_W  index of granted channel
//  gnt_onehot  out  N      one-hot of gnt_idx, all-zero when gnt_valid=0
//  rr_ptr      out  IDX_W  current round-robin top-priority index (debug/verification)
// BEHAVIOUR
//  Reset (async, rst_n=0, no clock needed): gnt_valid=0, gnt_idx=0, gnt_onehot=0, rr_ptr=N-1, state IDLE.
//  FSM states: IDLE, GRANT.
//   IDLE : |req=1 at edge -> winner registered, gnt_valid=1 from next cycle, go GRANT. |req=0 -> stay.
//   GRANT: gnt_idx/gnt_onehot/gnt_valid held stable while gnt_ready=0, regardless of req changes.
//          Handshake (gnt_valid & gnt_ready) at edge: update rr_ptr; if |req=1 same cycle,
//          re-arbitrate with the UPDATED pointer, stay GRANT (back-to-back, no bubble);
//          else gnt_valid->0, gnt_onehot->0, gnt_idx holds last value, go IDLE.
//  Latency: req to gnt_valid = 1 cycle; throughput 1 grant/cycle with gnt_ready tied high.
//  Fixed mode: highest set index wins.
//  Round-robin: search order rr_ptr, rr_ptr-1, ..., 0, N-1, ..., rr_ptr+1; first set bit wins.
//  Pointer update on handshake of grant g: rr_ptr <= (g==0) ? N-1 : g-1 (modulo-N wrap).
//   Pointer updates in both modes; with rr_ptr=N-1 RR result equals fixed result.
//  mode and req sampled only at arbitration edges; a mode change never disturbs a held grant.
//  Committed grant kept even if its req bit drops; consumer resolves that case.
//  Index arithmetic modulo N; N need not be a power of two (indices >= N never produced).
//  gnt_onehot always equals (1 << gnt_idx) when gnt_valid=1; exactly one bit set.
// STRUCTURE
//  Shared package prio_arb_pkg: state encodings (ST_IDLE, ST_GRANT), IDX_W helper,
//   wrap-decrement function dec_mod(idx, N).
//  Sub-module prio_pick: combinational, inputs req, top (start index), mode;
//   outputs found, idx. Implements rotate-then-highest-index search; instantiated once.
//  Top holds FSM, grant registers, rr_ptr register.
// TESTING (N=8)
//  1 Reset: assert rst_n=0 with clock stopped -> gnt_valid=0, gnt_onehot=0, gnt_idx=0, rr_ptr=7.
//  2 Fixed hold: mode=0, req=8'b0010_0101, ready=0 -> next cycle gnt_idx=5, onehot=8'h20;
//    change req to 8'h01 for 3 cycles -> grant unchanged; ready=1 -> rr_ptr=4, grant idx 0 next.
//  3 RR rotation: mode=1, req=8'hFF, ready=1 -> gnt_idx 7,6,5,4,3,2,1,0,7 on consecutive
//    cycles, gnt_valid continuously 1.
//  4 RR wrap: mode=1, req=8'h81, ready=1, from reset -> gnt_idx 7,0,7,0; rr_ptr 6,7,6,7.
//  5 Mode switch: after grant 4 accepted (rr_ptr=3), req=8'h18 -> mode=1 grants 3; mode=0 grants 4.
//  6 Reset mid-GRANT: grant 5 held (ready=0), pulse rst_n low between edges -> gnt_valid=0
//    immediately, rr_ptr=7; after release with req=8'h24, mode=1 -> grant 5 one cycle later.

Source files
------------

// File: rtl/prio_arb_pkg.sv
// rtl/prio_arb_pkg.sv - shared state encodings and index helpers for the registered arbiter
package prio_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Wrap-around decrement; the caller guarantees idx < n.
  function automatic int dec_mod(input int idx, input int n);
    return (idx == 0) ? n - 1 : idx - 1;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// rtl/prio_pick.sv - combinational rotate-then-highest-index request picker
module prio_pick
  import prio_arb_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] top,
  input  logic             mode,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  int               w_start;
  logic [IDX_W-1:0] w_cand;

  // Walk from lowest to highest priority so the last hit wins; fixed mode
  // is round-robin with the start index pinned at N-1.
  always_comb begin
    found   = 1'b0;
    idx     = '0;
    w_cand  = '0;
    w_start = mode ? int'(top) : N - 1;
    for (int k = N - 1; k >= 0; k--) begin
      w_cand = IDX_W'((w_start + N - k) % N);
      if (req[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/prio_rr_arbiter.sv
// rtl/prio_rr_arbiter.sv - registered N-way fixed/round-robin arbiter with valid/ready grant hold
module prio_rr_arbiter
  import prio_arb_pkg::*;
#(
  parameter  int N     = 8,
  localparam int IDX_W = idx_w(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             mode,
  input  logic             gnt_ready,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N-1:0]     gnt_onehot,
  output logic [IDX_W-1:0] rr_ptr
);

  state_t           r_state;
  state_t           w_next_state;
  logic [IDX_W-1:0] r_gnt_idx;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [N-1:0]     r_onehot;
  logic [IDX_W-1:0] w_ptr_next;
  logic [IDX_W-1:0] w_top;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_found;
  logic             w_accept;
  logic             w_arb_en;

  assign w_ptr_next = IDX_W'(dec_mod(int'(r_gnt_idx), N));

  prio_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req),
    .top   (w_top),
    .mode  (mode),
    .found (w_found),
    .idx   (w_pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_found) w_next_state = ST_GRANT;
      ST_GRANT: if (gnt_ready) w_next_state = w_found ? ST_GRANT : ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Back-to-back re-arbitration searches from the pointer the current
  // handshake is about to commit, not the stale one.
  always_comb begin
    w_accept = (r_state == ST_GRANT) && gnt_ready;
    w_arb_en = (r_state == ST_IDLE) || w_accept;
    w_top    = w_accept ? w_ptr_next : r_rr_ptr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt_idx <= '0;
      r_rr_ptr  <= IDX_W'(N - 1);
      r_onehot  <= '0;
    end else begin
      if (w_accept) begin
        r_rr_ptr <= w_ptr_next;
      end
      if (w_arb_en) begin
        if (w_found) begin
          r_gnt_idx <= w_pick_idx;
          r_onehot  <= {{(N-1){1'b0}}, 1'b1} << w_pick_idx;
        end else begin
          r_onehot  <= '0;
        end
      end
    end
  end

  assign gnt_valid  = (r_state == ST_GRANT);
  assign gnt_idx    = r_gnt_idx;
  assign gnt_onehot = r_onehot;
  assign rr_ptr     = r_rr_ptr;

endmodule

// File: tb/tb_prio_rr_arbiter.sv
// tb/tb_prio_rr_arbiter.sv - directed scoreboard bench for prio_rr_arbiter
module tb_prio_rr_arbiter;

  localparam int N = 8;

  logic       clk    = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst_n  = 1'b1;
  logic [7:0] req    = 8'h00;
  logic       mode   = 1'b0;
  logic       gnt_ready = 1'b0;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic [7:0] gnt_onehot;
  logic [2:0] rr_ptr;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 if (clk_en) clk = ~clk;

  prio_rr_arbiter #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .mode       (mode),
    .gnt_ready  (gnt_ready),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot),
    .rr_ptr     (rr_ptr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n     = 1'b1;
    req       = 8'h00;
    gnt_ready = 1'b0;
    mode      = 1'b0;
  endtask

  task automatic check_grant(input string tag);
    int e;
    chk({tag, "_sb_depth"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_valid"},  32'(gnt_valid),  32'd1);
      chk({tag, "_idx"},    32'(gnt_idx),    32'(e));
      chk({tag, "_onehot"}, 32'(gnt_onehot), 32'(8'h01 << e));
    end
  endtask

  task automatic get_ptr3();
    pulse_reset();
    mode = 1'b0; req = 8'h10; gnt_ready = 1'b1;
    step();
    req = 8'h00;
    step();
    chk("ptr3_rr", 32'(rr_ptr), 32'd3);
    chk("ptr3_idle", 32'(gnt_valid), 32'd0);
  endtask

  initial begin
    // 1: async reset with clock stopped
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_valid",  32'(gnt_valid),  32'd0);
    chk("rst_onehot", 32'(gnt_onehot), 32'd0);
    chk("rst_idx",    32'(gnt_idx),    32'd0);
    chk("rst_rr",     32'(rr_ptr),     32'd7);
    rst_n  = 1'b1;
    clk_en = 1'b1;
    @(negedge clk);

    // 2: fixed priority, held grant
    mode = 1'b0; req = 8'h25; gnt_ready = 1'b0;
    exp_q.push_back(5);
    step();
    check_grant("fix_first");
    req = 8'h01;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fix_hold_idx",    32'(gnt_idx),    32'd5);
      chk("fix_hold_onehot", 32'(gnt_onehot), 32'h20);
    end
    gnt_ready = 1'b1;
    exp_q.push_back(0);
    step();
    chk("fix_rr_after", 32'(rr_ptr), 32'd4);
    check_grant("fix_next");
    req = 8'h00;
    step();
    chk("fix_idle_valid",  32'(gnt_valid),  32'd0);
    chk("fix_idle_onehot", 32'(gnt_onehot), 32'd0);
    chk("fix_idle_idx",    32'(gnt_idx),    32'd0);
    chk("fix_idle_rr",     32'(rr_ptr),     32'd7);

    // 3: round-robin rotation, one grant per cycle
    pulse_reset();
    mode = 1'b1; req = 8'hFF; gnt_ready = 1'b1;
    for (int i = 0; i < 9; i++) exp_q.push_back((15 - i) % 8);
    for (int i = 0; i < 9; i++) begin
      step();
      check_grant("rr_rot");
    end
    req = 8'h00;
    step();

    // 4: round-robin wrap between channels 7 and 0
    pulse_reset();
    mode = 1'b1; req = 8'h81; gnt_ready = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back((i % 2 == 0) ? 7 : 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_grant("rr_wrap");
      if (i > 0) chk("rr_wrap_ptr", 32'(rr_ptr), (i % 2 == 1) ? 32'd6 : 32'd7);
    end
    req = 8'h00;
    step();

    // 5: mode switch with pointer at 3
    get_ptr3();
    mode = 1'b1; req = 8'h18; gnt_ready = 1'b0;
    exp_q.push_back(3);
    step();
    check_grant("mode_rr");
    mode = 1'b0;
    step();
    chk("mode_hold_idx", 32'(gnt_idx), 32'd3);
    get_ptr3();
    mode = 1'b0; req = 8'h18; gnt_ready = 1'b0;
    exp_q.push_back(4);
    step();
    check_grant("mode_fix");

    // 6: reset during a held grant
    pulse_reset();
    mode = 1'b0; req = 8'h20; gnt_ready = 1'b0;
    exp_q.push_back(5);
    step();
    check_grant("mid_pre");
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",  32'(gnt_valid),  32'd0);
    chk("mid_rst_onehot", 32'(gnt_onehot), 32'd0);
    chk("mid_rst_rr",     32'(rr_ptr),     32'd7);
    rst_n = 1'b1;
    mode = 1'b1; req = 8'h24;
    exp_q.push_back(5);
    step();
    check_grant("mid_post");

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
